// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//
// Shares the single register-file write port between two writeback
// requesters: port 0 (ALU) and port 1 (load/store unit). A registered write
// stage drives the register file. A per-register busy scoreboard lets issue
// logic detect RAW hazards on its two read addresses.
//
// Optional feature macro: RF_ARB_FIXED_PRIO_EN
//   defined   -> requester 1 always wins contention (no round-robin state)
//   undefined -> round-robin arbitration, requester 0 wins the first contention
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   req0_valid/addr/data     requester 0 write request
//   req0_ready               requester 0 granted this cycle
//   req1_valid/addr/data     requester 1 write request
//   req1_ready               requester 1 granted this cycle
//   rsv_ena, rsv_addr        issue reserves a destination register (mark busy)
//   rd_addr0, rd_addr1       registers read by issue
//   busy0, busy1             read address has an outstanding write
//   wr_ena/wr_addr/wr_data   register file write channel (registered)

module rf_write_arbiter #(
  parameter int unsigned REG_SIZE = 32,
  parameter int unsigned REG_NUM  = 32,
  localparam int unsigned AW      = $clog2(REG_NUM)
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                req0_valid,
  input  logic [AW-1:0]       req0_addr,
  input  logic [REG_SIZE-1:0] req0_data,
  output logic                req0_ready,

  input  logic                req1_valid,
  input  logic [AW-1:0]       req1_addr,
  input  logic [REG_SIZE-1:0] req1_data,
  output logic                req1_ready,

  input  logic                rsv_ena,
  input  logic [AW-1:0]       rsv_addr,
  input  logic [AW-1:0]       rd_addr0,
  input  logic [AW-1:0]       rd_addr1,
  output logic                busy0,
  output logic                busy1,

  output logic                wr_ena,
  output logic [AW-1:0]       wr_addr,
  output logic [REG_SIZE-1:0] wr_data
);

  logic                grant0;
  logic                grant1;
  logic                xfer;
  logic [AW-1:0]       win_addr;
  logic [REG_SIZE-1:0] win_data;

  logic                wr_ena_q, wr_ena_d;
  logic [AW-1:0]       wr_addr_q, wr_addr_d;
  logic [REG_SIZE-1:0] wr_data_q, wr_data_d;
  logic [REG_NUM-1:0]  busy_q, busy_d;

`ifdef RF_ARB_FIXED_PRIO_EN
  // Load/store always wins; no arbitration history needed.
  always_comb begin
    grant1 = req1_valid;
    grant0 = req0_valid && !req1_valid;
  end
`else
  // Index of the requester granted on the most recent transfer.
  logic rr_last_q, rr_last_d;

  always_comb begin
    grant0 = req0_valid && (!req1_valid || rr_last_q);
    grant1 = req1_valid && (!req0_valid || !rr_last_q);
  end

  always_comb begin
    rr_last_d = rr_last_q;
    if (grant0) begin
      rr_last_d = 1'b0;
    end else if (grant1) begin
      rr_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 || grant1;
  assign win_addr   = grant1 ? req1_addr : req0_addr;
  assign win_data   = grant1 ? req1_data : req0_data;

  // Write stage: a transfer to x0 is accepted but never reaches the RF.
  always_comb begin
    wr_ena_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_ena_d  = (win_addr != '0);
      wr_addr_d = win_addr;
      wr_data_d = win_data;
    end
  end

  // Scoreboard: the clear is applied first so a same-cycle reservation of
  // the committing register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_ena_q) begin
      busy_d[wr_addr_q] = 1'b0;
    end
    if (rsv_ena && (rsv_addr != '0)) begin
      busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ena_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wr_ena  = wr_ena_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

  // Not bypassed against the current commit: drops the cycle after.
  assign busy0 = busy_q[rd_addr0];
  assign busy1 = busy_q[rd_addr1];

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed testbench for rf_write_arbiter. Inputs change 1 time unit after a
// rising edge; combinational outputs are sampled 1 unit after the inputs and
// registered outputs 1 unit after the following rising edge.

module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rsv_ena;
  logic [4:0]  rsv_addr, rd_addr0, rd_addr1;
  logic        busy0, busy1;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int passed = 0;
  int total  = 0;

  rf_write_arbiter #(
    .REG_SIZE(32),
    .REG_NUM (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .rsv_ena   (rsv_ena),
    .rsv_addr  (rsv_addr),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .busy0     (busy0),
    .busy1     (busy1),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    rsv_ena = 1'b0; rsv_addr = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    total++;
    if (wr_ena !== 1'b0) $display("FAIL reset_wr_ena: got %b want 0", wr_ena);
    else passed++;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    total++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0)
      $display("FAIL idle_ready: got %b%b want 00", req0_ready, req1_ready);
    else passed++;
    total++;
    if (wr_ena !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0)
      $display("FAIL idle_wr: got %b/%0d/%h want 0/0/0", wr_ena, wr_addr, wr_data);
    else passed++;
    for (int a = 0; a < 32; a += 8) begin
      rd_addr0 = 5'(a);
      rd_addr1 = 5'(a + 5);
      #1;
      total++;
      if (busy0 !== 1'b0 || busy1 !== 1'b0)
        $display("FAIL idle_busy_%0d: got %b%b want 00", a, busy0, busy1);
      else passed++;
    end
  endtask

  task automatic test_single_write();
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    total++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
      $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
    else passed++;
    next_cycle();
    req0_valid = 1'b0;
    total++;
    if (wr_ena !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF)
      $display("FAIL single_wr: got %b/%0d/%h want 1/5/deadbeef", wr_ena, wr_addr, wr_data);
    else passed++;
    next_cycle();
    total++;
    if (wr_ena !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF)
      $display("FAIL single_hold: got %b/%0d/%h want 0/5/deadbeef", wr_ena, wr_addr, wr_data);
    else passed++;
  endtask

  task automatic test_contention();
    logic       exp0;
    logic [4:0] exp_addr;
    do_reset();
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h0000_0333;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h0000_0444;
    for (int i = 0; i < 4; i++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      exp0 = 1'b0;
`else
      exp0 = (i % 2 == 0);
`endif
      exp_addr = exp0 ? 5'd3 : 5'd4;
      #1;
      total++;
      if (req0_ready !== exp0 || req1_ready !== !exp0)
        $display("FAIL rr_ready_%0d: got %b%b want %b%b", i, req0_ready, req1_ready,
                 exp0, !exp0);
      else passed++;
      next_cycle();
      if (i == 3) idle_inputs();
      total++;
      if (wr_ena !== 1'b1 || wr_addr !== exp_addr || wr_data !== {20'd0, {3{1'b0, exp_addr[2:0]}}})
        $display("FAIL rr_wr_%0d: got %b/%0d/%h want 1/%0d", i, wr_ena, wr_addr, wr_data,
                 exp_addr);
      else passed++;
    end
  endtask

  task automatic test_zero_addr();
    idle_inputs();
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h1;
    #1;
    total++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
      $display("FAIL zero_ready: got %b%b want 01", req0_ready, req1_ready);
    else passed++;
    next_cycle();
    idle_inputs();
    total++;
    if (wr_ena !== 1'b0) $display("FAIL zero_wr_ena: got %b want 0", wr_ena);
    else passed++;
  endtask

  task automatic test_scoreboard();
    idle_inputs();
    rd_addr0 = 5'd7; rd_addr1 = 5'd0;
    rsv_ena = 1'b1; rsv_addr = 5'd7;
    #1;
    total++;
    if (busy0 !== 1'b0) $display("FAIL sb_pre_set: got %b want 0", busy0);
    else passed++;
    next_cycle();
    rsv_ena = 1'b0;
    total++;
    if (busy0 !== 1'b1) $display("FAIL sb_set: got %b want 1", busy0);
    else passed++;
    // Reserving x0 must never mark it busy.
    rsv_ena = 1'b1; rsv_addr = 5'd0;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h7777_0007;
    next_cycle();
    idle_inputs();
    total++;
    if (busy1 !== 1'b0) $display("FAIL sb_x0: got %b want 0", busy1);
    else passed++;
    total++;
    if (wr_ena !== 1'b1 || wr_addr !== 5'd7 || busy0 !== 1'b1)
      $display("FAIL sb_commit: got %b/%0d busy %b want 1/7 busy 1", wr_ena, wr_addr, busy0);
    else passed++;
    next_cycle();
    total++;
    if (busy0 !== 1'b0) $display("FAIL sb_clear: got %b want 0", busy0);
    else passed++;
  endtask

  task automatic test_set_wins_and_reset();
    idle_inputs();
    rd_addr0 = 5'd7; rd_addr1 = 5'd9;
    rsv_ena = 1'b1; rsv_addr = 5'd9;
    next_cycle();
    rsv_ena = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h9999_0009;
    next_cycle();
    req0_valid = 1'b0;
    // Commit of x9 happens at the next edge, together with a new reservation.
    rsv_ena = 1'b1; rsv_addr = 5'd9;
    total++;
    if (wr_ena !== 1'b1 || wr_addr !== 5'd9)
      $display("FAIL sw_commit: got %b/%0d want 1/9", wr_ena, wr_addr);
    else passed++;
    next_cycle();
    rsv_ena = 1'b0;
    total++;
    if (busy1 !== 1'b1) $display("FAIL sw_set_wins: got %b want 1", busy1);
    else passed++;
    rsv_ena = 1'b1; rsv_addr = 5'd7;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'hABCD_0009;
    next_cycle();
    idle_inputs();
    total++;
    if (wr_ena !== 1'b1 || busy0 !== 1'b1 || busy1 !== 1'b1)
      $display("FAIL rst_pre: got wr %b busy %b%b want 1 11", wr_ena, busy0, busy1);
    else passed++;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (wr_ena !== 1'b0) $display("FAIL rst_wr_ena: got %b want 0", wr_ena);
    else passed++;
    total++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL rst_busy: got %b%b want 00", busy0, busy1);
    else passed++;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    total++;
    if (wr_ena !== 1'b0 || busy0 !== 1'b0 || busy1 !== 1'b0)
      $display("FAIL rst_after: got wr %b busy %b%b want 0 00", wr_ena, busy0, busy1);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    rd_addr0 = '0;
    rd_addr1 = '0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_zero_addr();
    test_scoreboard();
    test_set_wins_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: port 0 (ALU) and port 1 (load/store unit).
- Uses round-robin arbitration and a registered write stage.
- Keeps a per-register busy scoreboard so that issue logic can detect RAW hazards on the two read addresses.
- Sits between the execute/memory stages and the register file write channel (wr_ena/wr_addr/wr_data).

Parameters:
- REG_SIZE, 32, data width of each register.
- REG_NUM, 32, number of architectural registers; register 0 is hardwired zero.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req0_valid  input  1  requester 0 has a write pending.
- req0_addr  input  $clog2(REG_NUM)  requester 0 destination register.
- req0_data  input  REG_SIZE  requester 0 write data.
- req0_ready  output  1  requester 0 granted this cycle.
- req1_valid, req1_addr, req1_data, req1_ready  same as port 0, for requester 1.
- rsv_ena  input  1  issue stage reserves a destination register.
- rsv_addr  input  $clog2(REG_NUM)  register to mark busy.
- rd_addr0, rd_addr1  input  $clog2(REG_NUM)  registers being read by issue.
- busy0, busy1  output  1  rd_addr0 / rd_addr1 has an outstanding write.
- wr_ena  output  1  to register file write enable.
- wr_addr  output  $clog2(REG_NUM)  to register file write address.
- wr_data  output  REG_SIZE  to register file write data.

Behaviour:
- Reset (async, rst=1) clears the following:
  - wr_ena=0, wr_addr=0, wr_data=0.
  - All busy bits = 0.
  - rr_last=1, so requester 0 wins the first contention.
- Grant is combinational from the valid inputs and rr_last:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to rr_last is granted.
  - Neither valid: no grant.
- reqN_ready = grant to N. Transfer occurs on a cycle with valid && ready.
- Requesters hold addr/data stable while valid && !ready.
- A ready is never asserted without a matching valid.
- rr_last updates to the granted index only on a transfer; it is unchanged on idle cycles.
- Output stage, one-cycle latency: the edge after a transfer loads wr_addr/wr_data from the winner and sets wr_ena=1.
  - A transfer with address 0 is accepted (ready=1) but sets wr_ena=0, so x0 is never written.
  - No transfer: wr_ena=0 next cycle; wr_addr/wr_data hold their previous values.
- Throughput: one write per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1.
- Scoreboard, busy[REG_NUM-1:0], where busy[0] is constantly 0:
  - Set: rsv_ena && rsv_addr!=0 sets busy[rsv_addr] at the clock edge.
  - Clear: wr_ena=1 clears busy[wr_addr] at the same edge the register file commits the write.
  - Set and clear on the same address in the same cycle: set wins (a new reservation supersedes).
  - Reserving an already-busy register: stays busy, no error.
  - A write to a non-busy register is legal; its busy bit stays 0.
- busyN = busy[rd_addrN] combinational. It is not bypassed against the current-cycle wr_ena, so it drops the cycle after the commit edge.
- Reset mid-operation: any in-flight output-stage write is discarded (wr_ena forced to 0 immediately) and all reservations are lost.

Optional Feature:
- RF_ARB_FIXED_PRIO_EN
  - Defined: requester 1 (load/store) always wins contention; rr_last is not implemented.
  - Undefined: round-robin as above.
  - Everything else is identical in both cases.

Test Plan:
- Reset, then idle: wr_ena=0, busy0=busy1=0 for all rd_addr, req0_ready=req1_ready=0.
- req0_valid=1, addr=5, data=32'hDEADBEEF, one cycle -> req0_ready=1 same cycle; next cycle wr_ena=1, wr_addr=5, wr_data=32'hDEADBEEF; following cycle wr_ena=0.
- Both valid for 4 cycles (req0 addr 3, req1 addr 4) -> ready pattern 0,1,0,1 (starting with requester 0); wr_addr sequence 3,4,3,4 one cycle later. With RF_ARB_FIXED_PRIO_EN: req1_ready=1 all four cycles, req0_ready=0.
- req1_valid=1, addr=0, data=32'h1 -> req1_ready=1; next cycle wr_ena=0.
- rsv_ena with rsv_addr=7; rd_addr0=7 -> busy0=1 from the next cycle. Then req0 writes addr 7 -> busy0 stays 1 through the commit cycle and reads 0 the cycle after.
- Same-cycle reserve and commit of addr 9 -> busy[9]=1 afterwards. Assert rst while wr_ena=1 -> wr_ena drops to 0 before the next clock edge and all busy bits read 0.
